// File: rtl/tiny_alu_arbiter.sv
// tiny_alu_arbiter: round-robin arbiter sharing one tiny ALU among NUM_REQ requesters.
// Optional watchdog enabled by TINY_ALU_ARB_TIMEOUT_EN.
module tiny_alu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*3-1:0]       req_op,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [2*DATA_W-1:0]        rsp_result,
  output logic                       rsp_err,
  output logic                       alu_start,
  output logic [2:0]                 alu_op,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic                       alu_done,
  input  logic [2*DATA_W-1:0]        alu_result
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, gnt, g, idx;
  logic any, op_alu, tmo, fin;
  logic [2:0] op_arr [NUM_REQ];
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[3*i +: 3];
    assign a_arr[i]  = req_a[DATA_W*i +: DATA_W];
    assign b_arr[i]  = req_b[DATA_W*i +: DATA_W];
  end
  // Descending scan so the requester closest to the pointer is chosen last and wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  assign op_alu    = op_arr[gnt] >= 3'd1 && op_arr[gnt] <= 3'd4;
  assign fin       = state == BUSY && (alu_done || tmo);
  assign req_ready = (state == IDLE && any) ? NUM_REQ'(1) << gnt : '0;
  assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << g : '0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (any ? (op_alu ? BUSY : RESP) : IDLE) :
              state == BUSY ? (fin ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      g          <= '0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
    end else if (state == IDLE && any) begin
      g          <= gnt;
      ptr        <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
      alu_op     <= op_arr[gnt];
      alu_a      <= a_arr[gnt];
      alu_b      <= b_arr[gnt];
      alu_start  <= op_alu;
      rsp_result <= '0;
    end else if (fin) begin
      alu_start  <= 1'b0;
      rsp_result <= alu_done ? alu_result : '0;
    end
  end
`ifdef TINY_ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic err;
  // A done arriving on the last watchdog cycle still counts as a normal completion.
  assign tmo     = state == BUSY && !alu_done && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign rsp_err = err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
      err <= (state == IDLE) ? 1'b0 : fin ? tmo : err;
    end
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_tiny_alu_arbiter.sv
// tb_tiny_alu_arbiter: directed self-checking bench for tiny_alu_arbiter.
module tb_tiny_alu_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*3-1:0] req_op = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [2*W-1:0] rsp_result;
  logic rsp_err, alu_start;
  logic [2:0] alu_op;
  logic [W-1:0] alu_a, alu_b;
  logic alu_done = 1'b0;
  logic [2*W-1:0] alu_result = '0;
  int checks = 0;
  int errors = 0;
  tiny_alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .alu_start(alu_start),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    return op == 3'd1 ? 16'(a) + 16'(b) : op == 3'd2 ? 16'(a & b) :
           op == 3'd3 ? 16'(a ^ b) : op == 3'd4 ? 16'(a) * 16'(b) : 16'h0;
  endfunction
  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_op[3*i +: 3] = op;
    req_a[W*i +: W] = a;
    req_b[W*i +: W] = b;
  endtask
  // Called at a falling edge with the DUT in IDLE; returns at a falling edge back in IDLE.
  task automatic txn(input int i, input int lat, input logic [15:0] exp, input bit keep);
    logic [2:0] op;
    logic [W-1:0] a, b;
    op = req_op[3*i +: 3];
    a = req_a[W*i +: W];
    b = req_b[W*i +: W];
    #1 check("ready", 32'(req_ready), 32'(1 << i));
    check("start_idle", 32'(alu_start), 0);
    @(negedge clk);
    if (!keep) req_valid[i] = 1'b0;
    if (op >= 3'd1 && op <= 3'd4)
      for (int c = 0; c < lat; c++) begin
        #1 check("start_busy", 32'(alu_start), 1);
        check("alu_op", 32'(alu_op), 32'(op));
        check("alu_a", 32'(alu_a), 32'(a));
        check("alu_b", 32'(alu_b), 32'(b));
        if (c == lat - 1) begin
          alu_done = 1'b1;
          alu_result = alu_f(alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        alu_done = 1'b0;
      end
    #1 check("rsp_valid", 32'(rsp_valid), 32'(1 << i));
    check("rsp_result", 32'(rsp_result), 32'(exp));
    check("rsp_err", 32'(rsp_err), 0);
    check("start_resp", 32'(alu_start), 0);
    @(negedge clk);
  endtask
  initial begin
    logic [15:0] xexp [N];
    xexp = '{16'h0055, 16'h003C, 16'h005A, 16'h00FF};
    repeat (2) @(negedge clk);
    #1 check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_result", 32'(rsp_result), 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_start", 32'(alu_start), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_req(2, 3'd1, 8'h0F, 8'h01);
    txn(2, 1, 16'h0010, 1'b0);
    set_req(0, 3'd4, 8'hFF, 8'hFF);
    txn(0, 3, 16'hFE01, 1'b0);
    set_req(1, 3'd0, 8'h12, 8'h34);
    txn(1, 0, 16'h0000, 1'b0);
    set_req(1, 3'd7, 8'h12, 8'h34);
    txn(1, 0, 16'h0000, 1'b0);
    set_req(3, 3'd4, 8'h12, 8'h34);
    #1 check("mul3_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    #1 check("mul3_start", 32'(alu_start), 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check("async_start", 32'(alu_start), 0);
    check("async_rsp_valid", 32'(rsp_valid), 0);
    check("async_alu_a", 32'(alu_a), 0);
    @(negedge clk);
    #1 check("rst_hold_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("post_rst_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    set_req(0, 3'd3, 8'h5A, 8'h0F);
    set_req(1, 3'd3, 8'h33, 8'h0F);
    set_req(2, 3'd3, 8'hF0, 8'hAA);
    set_req(3, 3'd3, 8'h81, 8'h7E);
    for (int t = 0; t < 8; t++) txn(t % N, 1, xexp[t % N], 1'b1);
    req_valid = '0;
`ifdef TINY_ALU_ARB_TIMEOUT_EN
    begin
      int n;
      set_req(0, 3'd1, 8'h01, 8'h02);
      #1 check("to_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = '0;
      n = 0;
      #1;
      while (alu_start === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
        #1;
      end
      check("to_busy_cycles", 32'(n), 16);
      check("to_rsp_valid", 32'(rsp_valid), 32'h1);
      check("to_rsp_err", 32'(rsp_err), 1);
      check("to_rsp_result", 32'(rsp_result), 0);
      @(negedge clk);
      set_req(1, 3'd2, 8'hF0, 8'h3C);
      txn(1, 2, 16'h0030, 1'b0);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
